// File: rtl/conv_layer_sched.sv
// conv_layer_sched
// Runs one conv_engine over a full convolution layer. The output channel is the
// outer loop and the input channel is the inner loop. Each (oc, ic) pass loads a
// 5x5 kernel, pulses the engine start, streams one MAPSIZE x MAPSIZE input plane
// and then waits for the engine to report completion.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 single-cycle layer start, sampled only in IDLE
//   num_in_ch/num_out_ch  channel counts, latched on an accepted start
//   hold                  pauses pixel issue while high (STREAM only)
//   busy, done            layer in progress / one-cycle end-of-layer pulse
//   w_rd_addr/w_rd_data   weight memory port, read latency 1
//   px_rd_addr/px_rd_data feature memory port, read latency 1
//   eng_start             engine start pulse
//   eng_data_valid        pixel strobe aligned with eng_pixel
//   eng_pixel             pixel to the engine (feature memory data)
//   eng_weights           kernel held for the engine, [row][col]
//   eng_all_done          engine completion pulse, honoured only in WAIT
//   cur_in_ch/cur_out_ch  channel indices of the current pass
//   first_in_ch/last_in_ch current pass is the first / last input channel
//
// Optional macro CONV_LAYER_SCHED_PERF_EN adds perf_cycles (cycles spent busy)
// and perf_stall (STREAM cycles with hold high), both cleared on accepted start.
module conv_layer_sched #(
  parameter int MAPSIZE    = 32,
  parameter int MAX_IN_CH  = 6,
  parameter int MAX_OUT_CH = 16,
  localparam int ICW = $clog2(MAX_IN_CH + 1),
  localparam int OCW = $clog2(MAX_OUT_CH + 1),
  localparam int WAW = $clog2(MAX_OUT_CH * MAX_IN_CH * 25),
  localparam int PAW = $clog2(MAX_IN_CH * MAPSIZE * MAPSIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ICW-1:0]               num_in_ch,
  input  logic [OCW-1:0]               num_out_ch,
  input  logic                         hold,
  output logic                         busy,
  output logic                         done,
  output logic [WAW-1:0]               w_rd_addr,
  input  logic signed [7:0]            w_rd_data,
  output logic [PAW-1:0]               px_rd_addr,
  input  logic signed [7:0]            px_rd_data,
  output logic                         eng_start,
  output logic                         eng_data_valid,
  output logic signed [7:0]            eng_pixel,
  output logic signed [4:0][4:0][7:0]  eng_weights,
  output logic [ICW-1:0]               cur_in_ch,
  output logic [OCW-1:0]               cur_out_ch,
  output logic                         first_in_ch,
  output logic                         last_in_ch,
`ifdef CONV_LAYER_SCHED_PERF_EN
  input  logic                         eng_all_done,
  output logic [31:0]                  perf_cycles,
  output logic [31:0]                  perf_stall
`else
  input  logic                         eng_all_done
`endif
);

  localparam int PLANE = MAPSIZE * MAPSIZE;
  localparam int PCW   = $clog2(PLANE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_KICK,
    S_STREAM,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t          r_state;
  logic [ICW-1:0]  r_n_in;
  logic [OCW-1:0]  r_n_out;
  logic [WAW-1:0]  r_wbase;   // (oc*num_in_ch + ic) * 25 as a running sum
  logic [PAW-1:0]  r_pbase;   // ic * MAPSIZE^2 as a running sum
  logic [4:0]      r_k;       // kernel load cycle, 0..25
  logic [PCW-1:0]  r_p;       // pixel index within the plane
  logic [199:0]    r_wflat;   // kernel as a flat shift register, tap k at bits k*8
  logic            w_counts_ok;

  assign w_counts_ok = (num_in_ch != '0) && (num_out_ch != '0);
  assign eng_pixel   = px_rd_data;
  assign eng_weights = r_wflat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_n_in         <= '0;
      r_n_out        <= '0;
      r_wbase        <= '0;
      r_pbase        <= '0;
      r_k            <= '0;
      r_p            <= '0;
      r_wflat        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      w_rd_addr      <= '0;
      px_rd_addr     <= '0;
      eng_start      <= 1'b0;
      eng_data_valid <= 1'b0;
      cur_in_ch      <= '0;
      cur_out_ch     <= '0;
      first_in_ch    <= 1'b0;
      last_in_ch     <= 1'b0;
    end else begin
      done           <= 1'b0;
      eng_start      <= 1'b0;
      eng_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_counts_ok) begin
              r_n_in      <= num_in_ch;
              r_n_out     <= num_out_ch;
              r_wbase     <= '0;
              r_pbase     <= '0;
              r_k         <= '0;
              w_rd_addr   <= '0;
              cur_in_ch   <= '0;
              cur_out_ch  <= '0;
              first_in_ch <= 1'b1;
              last_in_ch  <= (num_in_ch == ICW'(1));
              busy        <= 1'b1;
              r_state     <= S_LOAD_W;
            end else begin
              done    <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end

        // Address k is issued in cycle k; its data is shifted in during cycle
        // k+1, so after 25 shifts tap 0 holds the first word fetched.
        S_LOAD_W: begin
          if (r_k != 5'd0) begin
            r_wflat <= {w_rd_data, r_wflat[199:8]};
          end
          if (r_k < 5'd24) begin
            w_rd_addr <= w_rd_addr + WAW'(1);
          end
          if (r_k == 5'd25) begin
            eng_start <= 1'b1;
            r_state   <= S_KICK;
          end else begin
            r_k <= r_k + 5'd1;
          end
        end

        S_KICK: begin
          px_rd_addr <= r_pbase;
          r_p        <= '0;
          r_state    <= S_STREAM;
        end

        S_STREAM: begin
          if (!hold) begin
            eng_data_valid <= 1'b1;
            if (r_p == PCW'(PLANE - 1)) begin
              r_state <= S_WAIT;
            end else begin
              r_p        <= r_p + PCW'(1);
              px_rd_addr <= px_rd_addr + PAW'(1);
            end
          end
        end

        S_WAIT: begin
          if (eng_all_done) begin
            r_state <= S_NEXT;
          end
        end

        S_NEXT: begin
          r_wbase   <= r_wbase + WAW'(25);
          w_rd_addr <= r_wbase + WAW'(25);
          r_k       <= '0;
          if (cur_in_ch != r_n_in - ICW'(1)) begin
            cur_in_ch   <= cur_in_ch + ICW'(1);
            r_pbase     <= r_pbase + PAW'(PLANE);
            first_in_ch <= 1'b0;
            last_in_ch  <= (cur_in_ch + ICW'(1) == r_n_in - ICW'(1));
            r_state     <= S_LOAD_W;
          end else if (cur_out_ch == r_n_out - OCW'(1)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_FIN;
          end else begin
            cur_in_ch   <= '0;
            cur_out_ch  <= cur_out_ch + OCW'(1);
            r_pbase     <= '0;
            first_in_ch <= 1'b1;
            last_in_ch  <= (r_n_in == ICW'(1));
            r_state     <= S_LOAD_W;
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_LAYER_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (r_state == S_IDLE && start && w_counts_ok) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (r_state == S_STREAM && hold) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
module tb_conv_layer_sched;

  localparam int PLANE = 1024;

  typedef struct {
    int oc;
    int ic;
    int wbase;
    bit first;
    bit last;
  } pass_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic         eng_all_done = 1'b0;
  logic [2:0]   num_in_ch = '0;
  logic [4:0]   num_out_ch = '0;
  logic         busy, done, eng_start, eng_data_valid;
  logic [11:0]  w_rd_addr;
  logic [12:0]  px_rd_addr;
  logic [7:0]   w_rd_data = '0;
  logic [7:0]   px_rd_data = '0;
  logic [7:0]   eng_pixel;
  logic [4:0][4:0][7:0] eng_weights;
  logic [2:0]   cur_in_ch;
  logic [4:0]   cur_out_ch;
  logic         first_in_ch, last_in_ch;
`ifdef CONV_LAYER_SCHED_PERF_EN
  logic [31:0]  perf_cycles, perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pass_t      pass_q[$];
  logic [7:0] px_q[$];
  pass_t      cp;
  logic [199:0] cp_w;
  int  n_estart = 0, n_done = 0, pass_valids = 0, gap_cnt = 0, ad_cnt = 0;
  int  cyc = 0, start_cyc = 0, exp_gap = 0;
  bit  in_pass = 0;
  bit  hold_arm = 0, hold_used = 0;
  int  hold_at = 0, hold_cnt = 0;

  conv_layer_sched #(.MAPSIZE(32), .MAX_IN_CH(6), .MAX_OUT_CH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_in_ch(num_in_ch),
    .num_out_ch(num_out_ch), .hold(hold), .busy(busy), .done(done),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data), .px_rd_addr(px_rd_addr),
    .px_rd_data(px_rd_data), .eng_start(eng_start), .eng_data_valid(eng_data_valid),
    .eng_pixel(eng_pixel), .eng_weights(eng_weights), .cur_in_ch(cur_in_ch),
    .cur_out_ch(cur_out_ch), .first_in_ch(first_in_ch), .last_in_ch(last_in_ch),
`ifdef CONV_LAYER_SCHED_PERF_EN
    .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
    .eng_all_done(eng_all_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] wfn(input int a);
    logic [11:0] x;
    x = 12'(a);
    return x[7:0] ^ {x[11:8], x[11:8]};
  endfunction

  function automatic logic [7:0] pfn(input int a);
    logic [12:0] x;
    x = 13'(a);
    return x[7:0] + {x[12:8], 3'b000};
  endfunction

  // Latency-1 weight and feature memories.
  always @(posedge clk) begin
    w_rd_data  <= wfn(int'(w_rd_addr));
    px_rd_data <= pfn(int'(px_rd_addr));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard plus engine model.
  always @(negedge clk) begin
    logic [199:0] wf;
    cyc++;
    if (!rst_n) begin
      px_q.delete();
      in_pass      = 0;
      ad_cnt       = 0;
      eng_all_done = 1'b0;
    end else begin
      if (done) n_done++;
      eng_all_done = 1'b0;
      if (ad_cnt > 0) begin
        ad_cnt--;
        if (ad_cnt == 0) begin
          eng_all_done = 1'b1;
          wf = eng_weights;
          check_eq("wait_cur_in", 32'(cur_in_ch), 32'(cp.ic));
          check_eq("wait_cur_out", 32'(cur_out_ch), 32'(cp.oc));
          check_eq("wait_weights_stable", 32'(wf == cp_w), 1);
        end
      end
      if (eng_start) begin
        n_estart++;
        check_eq("pass_expected", 32'(pass_q.size() > 0), 1);
        if (pass_q.size() > 0) begin
          cp = pass_q.pop_front();
          check_eq("cur_out_ch", 32'(cur_out_ch), 32'(cp.oc));
          check_eq("cur_in_ch", 32'(cur_in_ch), 32'(cp.ic));
          check_eq("first_in_ch", 32'(first_in_ch), 32'(cp.first));
          check_eq("last_in_ch", 32'(last_in_ch), 32'(cp.last));
          wf = eng_weights;
          for (int k = 0; k < 25; k++) begin
            cp_w[k*8 +: 8] = wfn(cp.wbase + k);
            check_eq("weight", 32'(wf[k*8 +: 8]), 32'(cp_w[k*8 +: 8]));
          end
          for (int p = 0; p < PLANE; p++) px_q.push_back(pfn(cp.ic * PLANE + p));
          in_pass     = 1;
          pass_valids = 0;
          gap_cnt     = 0;
          start_cyc   = cyc;
        end
      end
      if (eng_data_valid) begin
        check_eq("pixel_expected", 32'(px_q.size() > 0), 1);
        if (px_q.size() > 0) check_eq("pixel", 32'(eng_pixel), 32'(px_q.pop_front()));
        if (pass_valids == 0) check_eq("strobe_latency_ge2", 32'((cyc - start_cyc) >= 2), 1);
        pass_valids++;
        if (pass_valids == PLANE) begin
          check_eq("stream_gap", 32'(gap_cnt), 32'(exp_gap));
          in_pass = 0;
          ad_cnt  = 10;
        end
      end else if (in_pass && pass_valids > 0) begin
        gap_cnt++;
      end
    end
  end

  // Hold generator: 7 stalled cycles once the target pixel is next to issue.
  always @(negedge clk) begin
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) hold = 1'b0;
    end else if (hold_arm && !hold_used && in_pass && int'(px_rd_addr) == hold_at) begin
      hold      = 1'b1;
      hold_cnt  = 7;
      hold_used = 1;
    end
  end

  task automatic start_layer(input int nin, input int nout);
    pass_t ps;
    for (int oc = 0; oc < nout; oc++) begin
      for (int ic = 0; ic < nin; ic++) begin
        ps.oc = oc; ps.ic = ic; ps.wbase = (oc * nin + ic) * 25;
        ps.first = (ic == 0); ps.last = (ic == nin - 1);
        pass_q.push_back(ps);
      end
    end
    num_in_ch  = 3'(nin);
    num_out_ch = 5'(nout);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer(input int nin, input int nout, input int gap, input bit poke);
    int es0, d0, b;
    exp_gap = gap;
    es0 = n_estart;
    d0  = n_done;
    start_layer(nin, nout);
    check_eq("busy_after_start", 32'(busy), 1);
    if (poke) begin
      b = 0;
      while (ad_cnt == 0 && b < 5000) begin @(negedge clk); b++; end
      check_eq("reached_wait", 32'(ad_cnt > 0), 1);
      num_in_ch = 3'd1; num_out_ch = 5'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    b = 0;
    while (!done && b < 20000) begin @(negedge clk); b++; end
    check_eq("done_seen", 32'(done), 1);
    @(negedge clk);
    check_eq("done_pulses", 32'(n_done - d0), 1);
    check_eq("done_one_cycle", 32'(done), 0);
    check_eq("busy_after_done", 32'(busy), 0);
    check_eq("eng_start_count", 32'(n_estart - es0), 32'(nin * nout));
    check_eq("passes_left", 32'(pass_q.size()), 0);
    check_eq("pixels_left", 32'(px_q.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_w_addr"}, 32'(w_rd_addr), 0);
    check_eq({tag, "_px_addr"}, 32'(px_rd_addr), 0);
    check_eq({tag, "_eng_start"}, 32'(eng_start), 0);
    check_eq({tag, "_valid"}, 32'(eng_data_valid), 0);
    check_eq({tag, "_weights"}, 32'(eng_weights == '0), 1);
    check_eq({tag, "_cur_in"}, 32'(cur_in_ch), 0);
    check_eq({tag, "_cur_out"}, 32'(cur_out_ch), 0);
    check_eq({tag, "_first"}, 32'(first_in_ch), 0);
    check_eq({tag, "_last"}, 32'(last_in_ch), 0);
  endtask

  initial begin
    int wa, pa, es0, d0, b;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single pass.
    run_layer(1, 1, 0, 0);

    // 2x2 layer with a stray start pulse during the first WAIT.
    run_layer(2, 2, 0, 1);

    // Hold for 7 cycles at p=500.
    hold_at  = 500;
    hold_arm = 1;
    run_layer(1, 1, 7, 0);
    hold_arm = 0;
`ifdef CONV_LAYER_SCHED_PERF_EN
    check_eq("perf_stall", perf_stall, 32'd7);
`endif

    // Zero output channels: immediate done, no memory or engine activity.
    wa  = int'(w_rd_addr);
    pa  = int'(px_rd_addr);
    es0 = n_estart;
    d0  = n_done;
    num_in_ch  = 3'd1;
    num_out_ch = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("zero_done", 32'(done), 1);
    @(negedge clk);
    check_eq("zero_done_clear", 32'(done), 0);
    check_eq("zero_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check_eq("zero_w_addr", 32'(w_rd_addr), 32'(wa));
    check_eq("zero_px_addr", 32'(px_rd_addr), 32'(pa));
    check_eq("zero_eng_start", 32'(n_estart), 32'(es0));
    check_eq("zero_done_pulses", 32'(n_done - d0), 1);

    // Reset in the middle of streaming.
    exp_gap = 0;
    d0 = n_done;
    start_layer(1, 1);
    b = 0;
    while (!(in_pass && px_rd_addr == 13'd300) && b < 5000) begin @(negedge clk); b++; end
    check_eq("reached_p300", 32'(px_rd_addr), 300);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_no_done", 32'(n_done - d0), 0);
    check_eq("midrst_idle_busy", 32'(busy), 0);
    run_layer(1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Sequences one conv_engine through a full convolution layer.
- Loop order: output channel (outer), then input channel (inner).
- For each (oc, ic) pass: loads the 5x5 kernel from weight memory, pulses the engine start, streams one MAPSIZE x MAPSIZE input plane from feature memory, then waits for the engine's all_done.
- Exports channel indices and first/last flags so the downstream accumulator sums partial maps across input channels.

Parameters:
- MAPSIZE, 32, input plane side length; must match the engine's MAPSIZE.
- MAX_IN_CH, 6, largest supported input channel count.
- MAX_OUT_CH, 16, largest supported output channel count.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle layer start; sampled only in IDLE
- num_in_ch  in  $clog2(MAX_IN_CH+1)  input channel count; latched on accepted start
- num_out_ch  in  $clog2(MAX_OUT_CH+1)  output channel count; latched on accepted start
- hold  in  1  pauses pixel issue while high
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at layer end
- w_rd_addr  out  $clog2(MAX_OUT_CH*MAX_IN_CH*25)  weight memory address; read latency 1
- w_rd_data  in  8 signed  weight memory data
- px_rd_addr  out  $clog2(MAX_IN_CH*MAPSIZE*MAPSIZE)  feature memory address; read latency 1
- px_rd_data  in  8 signed  feature memory data
- eng_start  out  1  engine start pulse
- eng_data_valid  out  1  engine pixel strobe
- eng_pixel  out  8 signed  engine pixel; equals px_rd_data
- eng_weights  out  8 signed [4:0][4:0]  kernel held for the engine
- eng_all_done  in  1  engine completion pulse
- cur_in_ch, cur_out_ch  out  channel widths  indices of the current pass
- first_in_ch, last_in_ch  out  1  current ic==0 / ic==num_in_ch-1

Behaviour:
- Reset values: all outputs 0, eng_weights 0, state IDLE. Reset mid-layer aborts immediately with no done pulse. The engine shares the reset domain at top level.
- States: IDLE, LOAD_W, KICK, STREAM, WAIT, NEXT, FIN.
- IDLE:
  - start=1 with both counts nonzero: latch counts, set busy, ic=oc=0, go to LOAD_W.
  - start=1 with either count 0: go to FIN with no memory or engine activity.
  - start while busy is ignored.
- LOAD_W:
  - Issues w_rd_addr = wbase+k for k=0..24, one per cycle.
  - Data returning the next cycle is written to eng_weights[k/5][k%5].
  - Occupies 26 cycles, then goes to KICK.
  - wbase = (oc*num_in_ch+ic)*25, maintained as a running sum (+25 per pass). No multiplier.
- KICK: eng_start=1 for exactly one cycle, then go to STREAM.
- STREAM:
  - Each cycle with hold=0, issues px_rd_addr = ic*MAPSIZE*MAPSIZE + p, with p=0..MAPSIZE^2-1.
  - eng_data_valid is the issue strobe delayed one cycle, aligned with px_rd_data.
  - hold=1 issues nothing; eng_data_valid drops 1 cycle later. p is not advanced.
  - After address MAPSIZE^2-1 is issued, go to WAIT.
  - Exactly MAPSIZE^2 valid strobes per pass. The first strobe is no earlier than 2 cycles after the eng_start cycle.
- WAIT: eng_weights, cur_* and flags stay stable until eng_all_done=1, then go to NEXT.
- NEXT:
  - ic<num_in_ch-1: ic++.
  - Otherwise: ic=0, oc++.
  - oc reaches num_out_ch: go to FIN; else go to LOAD_W.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- eng_all_done outside WAIT is ignored.
- hold has no effect outside STREAM.

Optional Feature:
- Macro: CONV_LAYER_SCHED_PERF_EN.
- Defined: adds output perf_cycles, 32 bits.
  - Cleared on accepted start.
  - Increments every cycle while busy.
  - Holds its value after done until the next start.
  - Also adds output perf_stall, 32 bits, counting STREAM cycles with hold=1.
- Undefined: neither port nor counter exists.

Test Plan:
- MAPSIZE=32, num_in_ch=1, num_out_ch=1, hold=0, engine model returning all_done 10 cycles after last valid:
  - w_rd_addr 0..24, then one eng_start, then 1024 consecutive valids with px_rd_addr 0..1023.
  - One done pulse.
  - first_in_ch=last_in_ch=1.
- num_in_ch=2, num_out_ch=2:
  - Pass order (oc,ic) = (0,0),(0,1),(1,0),(1,1).
  - wbase 0,25,50,75; pixel plane bases 0,1024,0,1024.
  - first/last flags correct on each pass.
  - 4 eng_start pulses total.
- hold=1 for 7 cycles at p=500:
  - No strobes during the gap.
  - Addresses resume at 500 with no skip or repeat.
  - Total valids still 1024.
- num_out_ch=0 with start=1:
  - done 1 cycle later; busy low again after done.
  - No w_rd, px_rd or eng_start activity.
- rst_n=0 at p=300:
  - Next cycle all outputs 0 and state IDLE, with no done pulse.
  - A following start re-runs from wbase 0.
- start pulsed during WAIT: ignored, with pass count unchanged. With CONV_LAYER_SCHED_PERF_EN and the test-3 stimulus: perf_stall=7.
